// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, ALU operations, result sources and immediate formats.
`default_nettype none

package riscv_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_fmt_t;

  // alt selects SUB over ADD (funct3 000) and SRA over SRL (funct3 101)
  function automatic alu_op_t alu_from_funct3(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_file.sv
// Architectural register file: two combinational read ports, one WB write port, x0 hardwired to 0.
`default_nettype none

module reg_file
  import riscv_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  output logic [XLEN-1:0]   rd1,
  output logic [XLEN-1:0]   rd2,
  input  logic              we,
  input  logic [REG_AW-1:0] rd,
  input  logic [XLEN-1:0]   wd
);

  logic [XLEN-1:0] regs [1:NUM_REGS-1];
  logic            wr_en;

  assign wr_en = we && (rd != '0);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[rd] <= wd;
    end
  end

  // Bypass is suppressed while in reset so reads see the cleared file, not the doomed write.
  function automatic logic [XLEN-1:0] read_port(input logic [REG_AW-1:0] addr);
    if (addr == '0) begin
      return '0;
    end else if (wr_en && RST && (rd == addr)) begin
      return wd;
    end else begin
      return regs[addr];
    end
  endfunction

  always_comb begin
    rd1 = read_port(rs1);
    rd2 = read_port(rs2);
  end

endmodule

`default_nettype wire

// File: rtl/decode.sv
// ID stage of the RV32I pipeline: control decode, immediate generation and register-file reads.
`default_nettype none

module decode
  import riscv_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [31:0]       Instr_D,
  input  logic [XLEN-1:0]   PC_D,
  input  logic [XLEN-1:0]   PC_Plus_4_D,
  input  logic              Reg_Write_W,
  input  logic [4:0]        Rd_W,
  input  logic [XLEN-1:0]   Result_W,
  output logic [XLEN-1:0]   RD1_D,
  output logic [XLEN-1:0]   RD2_D,
  output logic [4:0]        Rs1_D,
  output logic [4:0]        Rs2_D,
  output logic [4:0]        Rd_D,
  output logic [XLEN-1:0]   Imm_D,
  output logic              Reg_Write_D,
  output logic [1:0]        Result_Src_D,
  output logic              Mem_Write_D,
  output logic              Jump_D,
  output logic              Branch_D,
  output logic              ALU_Src_A_D,
  output logic              ALU_Src_B_D,
  output logic [3:0]        ALU_Ctrl_D,
  output logic [2:0]        Funct3_D,
  output logic              Illegal_D,
  output logic [XLEN-1:0]   PC_Out_D,
  output logic [XLEN-1:0]   PC_Plus_4_Out_D
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  logic        reg_write;
  result_src_t result_src;
  logic        mem_write;
  logic        jump;
  logic        branch;
  logic        src_a;
  logic        src_b;
  alu_op_t     alu_ctrl;
  imm_fmt_t    imm_fmt;
  logic        illegal;
  logic [31:0] imm32;

  assign opcode = Instr_D[6:0];
  assign funct3 = Instr_D[14:12];
  assign funct7 = Instr_D[31:25];

  assign Rs1_D           = Instr_D[19:15];
  assign Rs2_D           = Instr_D[24:20];
  assign Rd_D            = Instr_D[11:7];
  assign Funct3_D        = funct3;
  assign PC_Out_D        = PC_D;
  assign PC_Plus_4_Out_D = PC_Plus_4_D;

  reg_file #(
    .NUM_REGS (NUM_REGS),
    .XLEN     (XLEN)
  ) u_reg_file (
    .CLK (CLK),
    .RST (RST),
    .rs1 (Instr_D[19:15]),
    .rs2 (Instr_D[24:20]),
    .rd1 (RD1_D),
    .rd2 (RD2_D),
    .we  (Reg_Write_W),
    .rd  (Rd_W),
    .wd  (Result_W)
  );

  always_comb begin
    reg_write  = 1'b0;
    result_src = RES_ALU;
    mem_write  = 1'b0;
    jump       = 1'b0;
    branch     = 1'b0;
    src_a      = 1'b0;
    src_b      = 1'b0;
    alu_ctrl   = ALU_ADD;
    imm_fmt    = IMM_I;
    illegal    = 1'b0;

    case (opcode)
      OPC_LUI: begin
        reg_write = 1'b1;
        src_b     = 1'b1;
        alu_ctrl  = ALU_PASS_B;
        imm_fmt   = IMM_U;
      end
      OPC_AUIPC: begin
        reg_write = 1'b1;
        src_a     = 1'b1;
        src_b     = 1'b1;
        imm_fmt   = IMM_U;
      end
      OPC_JAL: begin
        reg_write  = 1'b1;
        jump       = 1'b1;
        result_src = RES_PC4;
        src_a      = 1'b1;
        src_b      = 1'b1;
        imm_fmt    = IMM_J;
      end
      OPC_JALR: begin
        reg_write  = 1'b1;
        jump       = 1'b1;
        result_src = RES_PC4;
        src_b      = 1'b1;
        illegal    = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        branch   = 1'b1;
        alu_ctrl = ALU_SUB;
        imm_fmt  = IMM_B;
        illegal  = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_LOAD: begin
        reg_write  = 1'b1;
        result_src = RES_MEM;
        src_b      = 1'b1;
        illegal    = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        mem_write = 1'b1;
        src_b     = 1'b1;
        imm_fmt   = IMM_S;
        illegal   = (funct3 > 3'b010);
      end
      OPC_OP_IMM: begin
        reg_write = 1'b1;
        src_b     = 1'b1;
        alu_ctrl  = alu_from_funct3(funct3, (funct3 == 3'b101) && Instr_D[30]);
        if (funct3 == 3'b001) begin
          illegal = (funct7 != 7'b0000000);
        end else if (funct3 == 3'b101) begin
          illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
        end
      end
      OPC_OP: begin
        reg_write = 1'b1;
        alu_ctrl  = alu_from_funct3(funct3, Instr_D[30]);
        if (funct7 == 7'b0100000) begin
          illegal = (funct3 != 3'b000) && (funct3 != 3'b101);
        end else begin
          illegal = (funct7 != 7'b0000000);
        end
      end
      OPC_FENCE: begin
        // Single-hart in-order core: memory ordering is already guaranteed.
      end
      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      reg_write = 1'b0;
      mem_write = 1'b0;
      jump      = 1'b0;
      branch    = 1'b0;
    end
  end

  always_comb begin
    imm32 = '0;
    case (imm_fmt)
      IMM_I:   imm32 = {{20{Instr_D[31]}}, Instr_D[31:20]};
      IMM_S:   imm32 = {{20{Instr_D[31]}}, Instr_D[31:25], Instr_D[11:7]};
      IMM_B:   imm32 = {{19{Instr_D[31]}}, Instr_D[31], Instr_D[7], Instr_D[30:25],
                        Instr_D[11:8], 1'b0};
      IMM_U:   imm32 = {Instr_D[31:12], 12'b0};
      IMM_J:   imm32 = {{11{Instr_D[31]}}, Instr_D[31], Instr_D[19:12], Instr_D[20],
                        Instr_D[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign Imm_D        = XLEN'($signed(imm32));
  assign Reg_Write_D  = reg_write;
  assign Result_Src_D = result_src;
  assign Mem_Write_D  = mem_write;
  assign Jump_D       = jump;
  assign Branch_D     = branch;
  assign ALU_Src_A_D  = src_a;
  assign ALU_Src_B_D  = src_b;
  assign ALU_Ctrl_D   = alu_ctrl;
  assign Illegal_D    = illegal;

endmodule

`default_nettype wire
